// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: widths, opcodes, FSM states.
// Pure declarations; no latency or backpressure of its own.
package alu_seq_pkg;
   localparam int W_DATA = 8;
   localparam int W_OP   = 3;

   localparam logic [W_OP-1:0] OP_PASS = 3'd0;
   localparam logic [W_OP-1:0] OP_ADD  = 3'd1;
   localparam logic [W_OP-1:0] OP_SUB  = 3'd2;
   localparam logic [W_OP-1:0] OP_AND  = 3'd3;
   localparam logic [W_OP-1:0] OP_XOR  = 3'd4;
   localparam logic [W_OP-1:0] OP_ABS  = 3'd5;
   localparam logic [W_OP-1:0] OP_MUL  = 3'd6;
   localparam logic [W_OP-1:0] OP_LOAD = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;
endpackage

// File: rtl/seq_fifo.sv
// Synchronous instruction FIFO; push visible at head one cycle later (no bypass).
// full blocks push and empty blocks pop; pointers carry an extra wrap bit.
module seq_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/alu_sequencer.sv
// Feeds buffered instructions to an external registered ALU; result 4 cycles after accept, 1 per 3 cycles.
// in_ready drops when the FIFO is full; each result is held until res_ready.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_OP-1:0]   in_opcode,
   input  logic [W_DATA-1:0] in_data,
   output logic [W_DATA-1:0] alu_accum,
   output logic [W_DATA-1:0] alu_data,
   output logic [W_OP-1:0]   alu_opcode,
   output logic              alu_rst,
   input  logic [W_DATA-1:0] alu_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W_DATA-1:0] res_value,
   output logic              res_zero,
   output logic [W_DATA-1:0] acc_value,
   output logic [7:0]        op_count,
   output logic              busy
);
   state_t                   state;
   logic [W_OP+W_DATA-1:0]   head;
   logic                     full;
   logic                     empty;
   logic                     pop;
   logic                     rst_hold;
   logic [W_OP-1:0]          op_reg;
   logic [W_DATA-1:0]        data_reg;
   logic [W_DATA-1:0]        acc;

   assign in_ready = !full;
   assign pop      = !empty && ((state == S_IDLE) ||
                                (state == S_RESP && res_valid && res_ready));

   seq_fifo #(.WIDTH(W_OP + W_DATA), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid && in_ready),
      .push_data ({in_opcode, in_data}),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         acc       <= '0;
         res_value <= '0;
         res_valid <= 1'b0;
         op_count  <= 8'd0;
         op_reg    <= '0;
         data_reg  <= '0;
         alu_accum <= '0;
      end else begin
         // ALU operands change only when a new instruction enters ISSUE
         if (pop) begin
            op_reg    <= head[W_OP+W_DATA-1 -: W_OP];
            data_reg  <= head[W_DATA-1:0];
            alu_accum <= acc;
         end
         case (state)
            S_IDLE:    if (pop) state <= S_ISSUE;
            S_ISSUE:   state <= S_CAPTURE;
            S_CAPTURE: begin
               acc       <= alu_out;
               res_value <= alu_out;
               res_valid <= 1'b1;
               op_count  <= op_count + 8'd1;
               state     <= S_RESP;
            end
            S_RESP: if (res_ready) begin
               res_valid <= 1'b0;
               state     <= pop ? S_ISSUE : S_IDLE;
            end
            default:   state <= S_IDLE;
         endcase
      end
   end

   // Stretches the ALU clear one cycle past reset release
   always_ff @(posedge clk) rst_hold <= !reset;

   assign alu_rst    = !reset || rst_hold;
   assign alu_data   = data_reg;
   assign alu_opcode = (state == S_ISSUE) ? op_reg : OP_PASS;
   assign res_zero   = (res_value == '0);
   assign acc_value  = acc;
   assign busy       = (state != S_IDLE) || !empty;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the registered ALU, scoreboards results in order,
// and runs directed plus random instruction streams.
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_opcode;
   logic [7:0] in_data;
   logic [7:0] alu_accum;
   logic [7:0] alu_data;
   logic [2:0] alu_opcode;
   logic       alu_rst;
   logic [7:0] alu_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_value;
   logic       res_zero;
   logic [7:0] acc_value;
   logic [7:0] op_count;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hs_cnt = 0;
   logic [7:0] acc_m = 8'd0;
   logic [7:0] exp_q [$];
   int hs_cyc [$];
   logic last_acc;
   logic [7:0] last_res;

   alu_sequencer #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_data(in_data), .alu_accum(alu_accum),
      .alu_data(alu_data), .alu_opcode(alu_opcode), .alu_rst(alu_rst),
      .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
      .res_value(res_value), .res_zero(res_zero), .acc_value(acc_value),
      .op_count(op_count), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] d);
      int s;
      case (op)
         3'd0: return a;
         3'd1: begin
            s = int'($signed(a)) + int'($signed(d));
            if (s > 127) return 8'h7F;
            if (s < -128) return 8'h80;
            return s[7:0];
         end
         3'd2: return a - d;
         3'd3: return a & d;
         3'd4: return a ^ d;
         3'd5: return d[7] ? (8'd0 - d) : d;
         3'd6: return {4'd0, a[3:0]} * {4'd0, d[3:0]};
         default: return d;
      endcase
   endfunction

   // External ALU: registered result, cleared by alu_rst
   always @(posedge clk) alu_out <= alu_rst ? 8'd0 : alu_f(alu_opcode, alu_accum, alu_data);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      logic [7:0] e;
      last_acc = 1'b0;
      if (reset) begin
         if (in_valid && in_ready) begin
            acc_m = alu_f(in_opcode, acc_m, in_data);
            exp_q.push_back(acc_m);
            last_acc = 1'b1;
         end
         if (res_valid && res_ready) begin
            hs_cyc.push_back(cyc);
            chk("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               hs_cnt++;
               chk("res_value", res_value, e);
               chk("res_zero", res_zero, e == 8'd0);
               chk("acc_value", acc_value, e);
               chk("op_count", op_count, 8'(hs_cnt));
               last_res = res_value;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] d);
      in_valid  = 1'b1;
      in_opcode = op;
      in_data   = d;
      for (int i = 0; i < 50; i++) begin
         step();
         if (last_acc) break;
      end
      in_valid = 1'b0;
      chk("send_accepted", last_acc, 1);
   endtask

   task automatic wait_res();
      for (int i = 0; i < 50 && !res_valid; i++) step();
      chk("wait_res_valid", res_valid, 1);
   endtask

   task automatic drain();
      res_ready = 1'b1;
      for (int i = 0; i < 300 && (busy || res_valid || exp_q.size() > 0); i++) step();
      chk("drain_empty", exp_q.size(), 0);
      chk("drain_idle", busy, 0);
   endtask

   initial begin
      int lat;
      reset = 1'b0; in_valid = 1'b0; res_ready = 1'b0; in_opcode = 3'd0; in_data = 8'd0;
      #1;
      repeat (3) step();
      chk("rst_alu_rst", alu_rst, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_acc", acc_value, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_res_value", res_value, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_opcode", alu_opcode, 0);
      reset = 1'b1;
      chk("rel_alu_rst_hold", alu_rst, 1);
      step();
      chk("rel_alu_rst_off", alu_rst, 0);
      chk("rel_in_ready", in_ready, 1);

      // Saturating add
      res_ready = 1'b1;
      send(OP_LOAD, 8'h70);
      send(OP_ADD, 8'h20);
      drain();
      chk("sat_last", last_res, 8'h7F);
      chk("sat_acc", acc_value, 8'h7F);
      chk("sat_count", op_count, 8'd2);

      // Nibble multiply then zero result
      send(OP_LOAD, 8'h03);
      send(OP_MUL, 8'h05);
      drain();
      chk("mul_last", last_res, 8'h0F);
      chk("mul_zero", res_zero, 0);
      send(OP_AND, 8'h00);
      drain();
      chk("and_last", last_res, 8'h00);
      chk("and_zero", res_zero, 1);

      // Result held under backpressure
      res_ready = 1'b0;
      send(OP_LOAD, 8'hF0);
      send(OP_XOR, 8'hFF);
      wait_res();
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", res_valid, 1);
         chk("hold_value", res_value, 8'hF0);
         step();
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      wait_res();
      chk("xor_value", res_value, 8'h0F);
      drain();

      // Latency from accept into an idle, empty sequencer
      res_ready = 1'b0;
      in_valid = 1'b1; in_opcode = OP_SUB; in_data = 8'h01;
      step();
      in_valid = 1'b0;
      chk("lat_accept", last_acc, 1);
      lat = 1;
      while (!res_valid && lat < 20) begin
         step();
         lat++;
      end
      chk("latency", lat, 4);
      drain();

      // Back-to-back throughput
      res_ready = 1'b0;
      send(OP_ADD, 8'h11);
      send(OP_SUB, 8'h05);
      send(OP_XOR, 8'h3C);
      wait_res();
      hs_cyc.delete();
      res_ready = 1'b1;
      for (int i = 0; i < 40 && hs_cyc.size() < 3; i++) step();
      chk("tput_count", hs_cyc.size(), 3);
      if (hs_cyc.size() == 3) begin
         chk("tput_gap0", hs_cyc[1] - hs_cyc[0], 3);
         chk("tput_gap1", hs_cyc[2] - hs_cyc[1], 3);
      end
      drain();

      // FIFO fill: 5 accepted, 6th stalls until the first handshake
      res_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         in_valid = 1'b1;
         in_opcode = 3'($urandom_range(0, 7));
         in_data = 8'($urandom);
         for (int i = 0; i < 20; i++) begin
            step();
            if (last_acc) break;
         end
         chk("fill_accept", last_acc, 1);
      end
      chk("fill_full", in_ready, 0);
      in_opcode = OP_ADD; in_data = 8'h42;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("fill_stall_acc", last_acc, 0);
         chk("fill_stall_rdy", in_ready, 0);
      end
      res_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (last_acc) break;
      end
      in_valid = 1'b0;
      chk("fill_sixth", last_acc, 1);
      drain();

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_opcode = 3'($urandom_range(0, 7));
         in_data   = 8'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0;
      drain();

      // Reset during CAPTURE
      res_ready = 1'b0;
      send(OP_LOAD, 8'h55);
      step();
      step();
      chk("mid_busy", busy, 1);
      reset = 1'b0;
      step();
      exp_q.delete();
      acc_m = 8'd0;
      hs_cnt = 0;
      chk("mid_res_valid", res_valid, 0);
      chk("mid_acc", acc_value, 0);
      chk("mid_op_count", op_count, 0);
      chk("mid_in_ready", in_ready, 1);
      chk("mid_alu_rst1", alu_rst, 1);
      reset = 1'b1;
      chk("mid_alu_rst2", alu_rst, 1);
      step();
      chk("mid_alu_rst_off", alu_rst, 0);
      res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("mid_no_result", res_valid, 0);
         step();
      end
      send(OP_LOAD, 8'h11);
      drain();
      chk("post_count", op_count, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of buffered instructions (power of two, >=2).
REQ-002 Reset and clock: reset reset, synchronous, active-low; clock clk.
REQ-003 clk  input  1  rising-edge clock, shared with the ALU.
REQ-004 reset  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  instruction FIFO not full.
REQ-007 in_opcode  input  3  ALU opcode (000 pass, 001 sat-add, 010 sub, 011 and, 100 xor, 101 abs, 110 nibble-mul, 111 load).
REQ-008 in_data  input  8  operand.
REQ-009 alu_accum  output  8  accumulator operand to ALU.
REQ-010 alu_data  output  8  data operand to ALU.
REQ-011 alu_opcode  output  3  opcode to ALU.
REQ-012 alu_rst  output  1  active-high clear to ALU.
REQ-013 alu_out  input  8  registered ALU result.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  downstream accepts result.
REQ-016 res_value  output  8  result byte.
REQ-017 res_zero  output  1  res_value == 0.
REQ-018 acc_value  output  8  current accumulator.
REQ-019 op_count  output  8  completed-instruction count, wraps 0xFF->0x00.
REQ-020 busy  output  1  state != IDLE or FIFO non-empty.

Function
REQ-021 Push {in_opcode,in_data} into FIFO when in_valid && in_ready; in_ready = !full, registered-state based, no full-bypass on same-cycle pop.
REQ-022 FSM states IDLE, ISSUE, CAPTURE, RESP; one state per cycle except RESP.
REQ-023 IDLE: FIFO non-empty -> pop head into op_reg/data_reg, go ISSUE; else stay; no empty-bypass (push to empty FIFO visible next cycle).
REQ-024 ISSUE: alu_opcode=op_reg, alu_data=data_reg, alu_accum=acc; ALU samples at end of cycle; go CAPTURE.
REQ-025 CAPTURE: at cycle end acc<=alu_out, res_value<=alu_out, res_valid<=1, op_count<=op_count+1; go RESP.
REQ-026 RESP: res_valid, res_value, res_zero held stable until res_ready; on res_valid&&res_ready, res_valid<=0, then pop+ISSUE if FIFO non-empty else IDLE.
REQ-027 alu_opcode/alu_data/alu_accum held constant in all states except ISSUE-entry update; outside ISSUE alu_opcode=000.
REQ-028 Latency: accepted into empty FIFO with idle FSM at cycle N -> res_valid=1 at cycle N+4; back-to-back throughput one result per 3 cycles with res_ready=1.
REQ-029 res_zero computed locally from res_value (ALU zero flag reflects operand, not result, and is not used).
REQ-030 Accumulator is 8-bit, overwritten only in CAPTURE; no other writes.

Reset
REQ-031 reset==0 at a clock edge: state=IDLE, FIFO emptied, acc=0, res_value=0, res_valid=0, op_count=0, op_reg=0, data_reg=0; in_ready=1 next cycle.
REQ-032 alu_rst=1 while reset==0 and for one cycle after release; 0 otherwise.
REQ-033 Reset mid-operation (any state) discards in-flight and buffered instructions; no result emitted.

Structure
REQ-034 Shared package alu_seq_pkg: state enum, opcode constants (OP_PASS..OP_LOAD), width constants (W_DATA=8, W_OP=3).
REQ-035 One sub-module: seq_fifo (synchronous FIFO, width 11, depth FIFO_DEPTH, full/empty flags, pointer wrap via extra MSB).

Verification
REQ-036 Push LOAD 0x70, ADD 0x20, res_ready=1 -> results 0x70 then 0x7F (saturation), acc_value=0x7F, op_count=2.
REQ-037 Push LOAD 0x03, MUL 0x05 -> second result 0x0F, res_zero=0; then AND 0x00 -> 0x00, res_zero=1.
REQ-038 Push LOAD 0xF0, XOR 0xFF with res_ready=0 for 10 cycles -> res_valid=1 holding 0xF0 stable; after res_ready pulse next result 0x0F.
REQ-039 res_ready=0, push 6 back-to-back -> first popped, 4 buffered, in_ready=0 from cycle after 5th accept until first RESP handshake; 6th held by producer, none lost.
REQ-040 Reset pulsed during CAPTURE -> next cycle res_valid=0, acc_value=0, op_count=0, in_ready=1, alu_rst=1 for two cycles.
